pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze and watchdog.
// Define PIPE_HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       mem_branch_taken,
  input  logic       mem_wait,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       pipe_en,
  output logic [1:0] state,
  output logic       timeout_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10,
    ST_ILL  = 2'b11
  } stateT;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  stateT      state_q, state_d;
  logic [7:0] waitCnt_q, waitCnt_d;
  logic       pendFlush_q, pendFlush_d;
  logic       timeoutErr_q, timeoutErr_d;
  logic       loadUse;
  logic       branchTerm;

  assign loadUse    = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign branchTerm = mem_branch_taken || pendFlush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      waitCnt_q    <= 8'd0;
      pendFlush_q  <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      pendFlush_q  <= pendFlush_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // The counter already holds 1 on the first WAIT cycle, so it equals the length of the wait so far.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    pendFlush_d  = pendFlush_q;
    timeoutErr_d = timeoutErr_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    pipe_en      = 1'b0;

    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (mem_wait) begin
          pendFlush_d = pendFlush_q || mem_branch_taken;
          if (state_q == ST_RUN) begin
            state_d   = ST_WAIT;
            waitCnt_d = 8'd1;
          end else if (waitCnt_q >= WaitMax) begin
            state_d      = ST_ERR;
            timeoutErr_d = 1'b1;
          end else if (waitCnt_q != 8'hFF) begin
            waitCnt_d = waitCnt_q + 8'd1;
          end
        end else begin
          state_d     = ST_RUN;
          waitCnt_d   = 8'd0;
          pendFlush_d = 1'b0;
          pipe_en     = 1'b1;
          if (branchTerm) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end else if (loadUse) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end
      ST_ERR: begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
      end
      default: begin
        state_d     = ST_RUN;
        waitCnt_d   = 8'd0;
        pendFlush_d = 1'b0;
      end
    endcase

    // Hold the whole pipeline quiet while reset is asserted.
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      pipe_en      = 1'b0;
    end
  end

  assign state       = state_q;
  assign timeout_err = timeoutErr_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= 16'd0;
      flushCnt_q <= 16'd0;
    end else begin
      if (!pc_write)  stallCnt_q <= stallCnt_q + 16'd1;
      if (ifid_flush) flushCnt_q <= flushCnt_q + 16'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int WaitMax = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, mem_branch_taken, mem_wait;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_en;
  logic [1:0] state;
  logic       timeout_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checkCount = 0;
  int failCount  = 0;

  // Model of the controller: wait-run length, pending branch, error latch.
  bit mInErr, mPending;
  int mWaitRun;
  int mStall, mFlush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(WaitMax)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_wait(mem_wait),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .pipe_en(pipe_en),
    .state(state), .timeout_err(timeout_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_en}.
  function automatic logic [5:0] expOuts(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                                         input logic [4:0] er, input logic br, input logic mw);
    logic lu;
    lu = mr && (er != 0) && ((er == rs) || (er == rt));
    if (mInErr)            return 6'b001110;
    if (mw)                return 6'b000000;
    if (br || mPending)    return 6'b111111;
    if (lu)                return 6'b000101;
    return 6'b110001;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                               input logic [4:0] er, input logic br, input logic mw);
    logic [5:0] exp;
    @(negedge clk);
    id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = er; mem_branch_taken = br; mem_wait = mw;
    #1;
    exp = expOuts(rs, rt, mr, er, br, mw);
    checkOutput("outs", {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_en}, {26'd0, exp});
    checkOutput("state", {30'd0, state}, mInErr ? 32'd2 : (mWaitRun > 0 ? 32'd1 : 32'd0));
    checkOutput("timeout", {31'd0, timeout_err}, {31'd0, mInErr});
    @(posedge clk);
    if (!exp[5]) mStall++;
    if (exp[3])  mFlush++;
    if (!mInErr) begin
      if (mw) begin
        mWaitRun++;
        mPending = mPending || br;
        if (mWaitRun > WaitMax) mInErr = 1'b1;
      end else begin
        mWaitRun = 0;
        mPending = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    id_rs = 5'd3; id_rt = 5'd3; ex_memread = 1'b1; ex_rt = 5'd3; mem_branch_taken = 1'b1; mem_wait = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("rstOuts", {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_en}, 32'd0);
    checkOutput("rstState", {30'd0, state}, 32'd0);
    checkOutput("rstTimeout", {31'd0, timeout_err}, 32'd0);
    mInErr = 1'b0; mPending = 1'b0; mWaitRun = 0; mStall = 0; mFlush = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] rs, rt, er;
    logic       mr, br, mw;
    rst_n = 1'b1;
    id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0; mem_branch_taken = 1'b0; mem_wait = 1'b0;
    #3;
    doReset();

    // Directed: load-use, r0 exemption, branch over load-use, branch during wait.
    applyStimulus(5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(5'd4, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);

    // Randomized traffic with bursts of memory wait and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rs = 5'($urandom); rt = 5'($urandom);
      mr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: er = rs;
        1: er = rt;
        2: er = 5'd0;
        default: er = 5'($urandom);
      endcase
      br = ($urandom_range(0, 5) == 0);
      mw = (mWaitRun > 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 4) == 0);
      applyStimulus(rs, rt, mr, er, br, mw);
`ifdef PIPE_HAZARD_PERF_EN
      if (i == 599) begin
        #1;
        checkOutput("stallCntRand", {16'd0, stall_cnt}, 32'(mStall & 16'hFFFF));
        checkOutput("flushCntRand", {16'd0, flush_cnt}, 32'(mFlush & 16'hFFFF));
      end
`endif
      if ($urandom_range(0, 79) == 0) doReset();
    end

    // Watchdog: hold memory wait for WAIT_MAX+1 cycles.
    doReset();
    for (int i = 0; i < WaitMax + 1; i++) applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("errState", {30'd0, state}, 32'd2);
    checkOutput("errFlag", {31'd0, timeout_err}, 32'd1);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    doReset();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);

`ifdef PIPE_HAZARD_PERF_EN
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd7, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
    end
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("stallCnt", {16'd0, stall_cnt}, 32'd4);
    checkOutput("flushCnt", {16'd0, flush_cnt}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
